color_palette_ctrl: RTL and testbench
=====================================

Name: color_palette_ctrl

Overview:
Parametrised palette (colour) RAM controller for the video back end. Selects one of NUM_LAYERS pixel indices per pixel through a priority select, combines it with a bank select to form a palette address, and reads a DATA_W colour word toward the monitor interface. It shares a single-port palette store with a CPU port through a wait/ack handshake that has bounded starvation.

Parameters:
DATA_W, 16, colour word width (also the CPU data width)
IDX_W, 8, per-layer pixel index width
BANK_W, 2, palette bank select width; address width ADDR_W = BANK_W + IDX_W
NUM_LAYERS, 4, number of layer index inputs; must be >= 2
STARVE_MAX, 8, maximum number of cycles a pending CPU request waits before it forces a slot; must be >= 1

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
pix_valid  in  1  a pixel is presented this cycle
layer_idx  in  NUM_LAYERS*IDX_W  packed layer indices; layer n occupies bits [n*IDX_W +: IDX_W]
layer_sel  in  $clog2(NUM_LAYERS)  winning layer chosen by priority control
bank_sel  in  BANK_W  palette bank; forms the upper address bits
color_out  out  DATA_W  colour word
color_valid  out  1  color_out corresponds to a presented pixel
cpu_req  in  1  CPU access request; held high until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
cpu_addr  in  ADDR_W  palette address
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data; valid in the cpu_ack cycle
cpu_ack  out  1  single-cycle completion pulse

Behaviour:
- Reset: color_out=0, color_valid=0, cpu_ack=0, cpu_rdata=0, pipeline valid bits=0, starvation counter=0, FSM=IDLE. Palette contents are not reset.
- Out-of-range layer_sel (when NUM_LAYERS is not a power of 2) selects layer 0.
- Storage: 2^ADDR_W x DATA_W, single port, synchronous read, one access per cycle.
- Video pipeline:
  - S1 registers addr = {bank_sel, layer_idx[layer_sel]} and v1 = pix_valid.
  - S2 issues the RAM read when v1=1 and the port is granted to video.
  - color_out and color_valid register the result.
  - Latency: pix_valid at cycle t -> color_valid at t+2.
  - Back-to-back pixels are supported at full rate.
- Port arbitration, each cycle:
  - Video owns the port when v1=1, unless a forced CPU grant occurs.
  - The CPU is granted when v1=0, or when the starvation counter equals STARVE_MAX.
- CPU FSM:
  - IDLE -> WAIT on cpu_req.
  - WAIT -> ACCESS on grant. The counter increments each WAIT cycle without a grant and saturates at STARVE_MAX.
  - A grant in the same cycle as the request goes IDLE -> ACCESS directly.
  - ACCESS performs the RAM write or read. Next cycle is ACK: cpu_ack=1, cpu_rdata=read word (a write returns cpu_wdata). Counter clears.
  - ACK -> IDLE. A new request is accepted from IDLE only, so the minimum spacing is 3 cycles.
- Forced grant (stolen slot):
  - The pixel in S1 is not read; color_valid is still asserted at t+2 so pixel timing is preserved.
  - color_out holds the previous colour (see optional feature).
- Write/read collision: a CPU write to address A followed by a video read of A in the next cycle returns the new data. There is no same-cycle case because the port is single.
- Reset mid-operation: an in-flight CPU access is abandoned with no cpu_ack; a write is committed only if its ACCESS cycle completed before rst.
- cpu_req dropped before ack: the FSM returns to IDLE from WAIT. Once the FSM is in ACCESS, the access completes and cpu_ack is still issued.

Optional Feature:
Macro: COLOR_PALETTE_SNOW_EN.
- Defined: on a stolen slot, color_out = cpu_wdata for a CPU write, or the CPU read data for a CPU read. This reproduces the classic CPU-access "snow" artefact on screen.
- Not defined: color_out repeats the last valid colour on a stolen slot.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset, then CPU write 0x7C1F to address 0x105 with pix_valid=0 -> cpu_ack exactly 2 cycles after grant; a CPU read of 0x105 returns cpu_rdata=0x7C1F with cpu_ack.
- Preload 0x105=0x7C1F; drive bank_sel=1, layer_sel=2, layer_idx lane2=0x05, pix_valid=1 at cycle t -> color_valid=1 and color_out=0x7C1F at t+2; continuous pixels produce one colour per cycle.
- Continuous pix_valid=1 with CPU write pending, STARVE_MAX=8 -> cpu_ack no later than 10 cycles after cpu_req; the stolen pixel gives color_valid=1 with previous colour (no macro) or cpu_wdata (COLOR_PALETTE_SNOW_EN).
- CPU request while pix_valid toggles 1,0 -> grant on the first v1=0 cycle; counter clears; no pixel is lost.
- Assert rst for 1 cycle while the FSM is in WAIT -> no cpu_ack, color_valid=0 the next cycle, target address unchanged.
- layer_sel sweep 0..3 with distinct lane indices -> color_out matches the palette entry of the selected lane each cycle.

Source files
------------

// File: rtl/color_palette_ctrl.sv
// Palette RAM controller: layer-priority pixel lookup sharing a single-port palette with a CPU port.
// Optional macro COLOR_PALETTE_SNOW_EN shows CPU data on stolen video slots instead of the held colour.
module color_palette_ctrl #(
  parameter  int DATA_W     = 16,
  parameter  int IDX_W      = 8,
  parameter  int BANK_W     = 2,
  parameter  int NUM_LAYERS = 4,
  parameter  int STARVE_MAX = 8,
  localparam int ADDR_W     = BANK_W + IDX_W,
  localparam int SEL_W      = $clog2(NUM_LAYERS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pix_valid,
  input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
  input  logic [SEL_W-1:0]            layer_sel,
  input  logic [BANK_W-1:0]           bank_sel,
  output logic [DATA_W-1:0]           color_out,
  output logic                        color_valid,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wdata,
  output logic [DATA_W-1:0]           cpu_rdata,
  output logic                        cpu_ack
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, ACK} cpu_state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  cpu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic              v1_q, v1_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic              color_valid_q, color_valid_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_we_q, cpu_we_d;
  logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
  logic [DATA_W-1:0] cpu_wdata_q, cpu_wdata_d;

  logic [IDX_W-1:0]  sel_idx;
  logic              port_cpu;
  logic              port_we;
  logic [ADDR_W-1:0] port_addr;
  logic [DATA_W-1:0] port_rdata;
  logic              forced;
  logic              grant;

  // Lane 0 is the default, which also covers out-of-range selects.
  always_comb begin
    sel_idx = layer_idx[IDX_W-1:0];
    for (int i = 1; i < NUM_LAYERS; i++) begin
      if (layer_sel == SEL_W'(i)) sel_idx = layer_idx[i*IDX_W +: IDX_W];
    end
  end

  // The single port belongs to the CPU only in its ACCESS cycle.
  assign port_cpu   = (state_q == ACCESS);
  assign port_addr  = port_cpu ? cpu_addr_q : addr1_q;
  assign port_we    = port_cpu && cpu_we_q && !rst;
  assign port_rdata = mem[port_addr];

  // NOTE: the storage array has no reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (port_we) mem[port_addr] <= cpu_wdata_q;
  end

  always_comb begin
    addr1_d       = {bank_sel, sel_idx};
    v1_d          = pix_valid;
    color_valid_d = v1_q;
    color_d       = color_q;
    if (v1_q && !port_cpu) color_d = port_rdata;
`ifdef COLOR_PALETTE_SNOW_EN
    if (v1_q && port_cpu) color_d = cpu_we_q ? cpu_wdata_q : port_rdata;
`else
    if (v1_q && port_cpu) color_d = color_q;
`endif
  end

  // A grant reserves the next cycle's port slot, which is free when no pixel enters S1.
  assign forced = (starve_q == CNT_W'(STARVE_MAX));
  assign grant  = cpu_req && (state_q == IDLE || state_q == WAIT) && (!pix_valid || forced);

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    cpu_we_d    = cpu_we_q;
    cpu_addr_d  = cpu_addr_q;
    cpu_wdata_d = cpu_wdata_q;
    unique case (state_q)
      IDLE, WAIT: begin
        if (!cpu_req) begin
          state_d  = IDLE;
          starve_d = '0;
        end else if (grant) begin
          state_d     = ACCESS;
          cpu_we_d    = cpu_we;
          cpu_addr_d  = cpu_addr;
          cpu_wdata_d = cpu_wdata;
        end else begin
          state_d = WAIT;
          if (!forced) starve_d = starve_q + 1'b1;
        end
      end
      ACCESS: begin
        state_d     = ACK;
        starve_d    = '0;
        cpu_ack_d   = 1'b1;
        cpu_rdata_d = cpu_we_q ? cpu_wdata_q : port_rdata;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every register below is state, so all updates are non-blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      starve_q      <= '0;
      addr1_q       <= '0;
      v1_q          <= 1'b0;
      color_q       <= '0;
      color_valid_q <= 1'b0;
      cpu_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      cpu_we_q      <= 1'b0;
      cpu_addr_q    <= '0;
      cpu_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      addr1_q       <= addr1_d;
      v1_q          <= v1_d;
      color_q       <= color_d;
      color_valid_q <= color_valid_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_we_q      <= cpu_we_d;
      cpu_addr_q    <= cpu_addr_d;
      cpu_wdata_q   <= cpu_wdata_d;
    end
  end

  assign color_out   = color_q;
  assign color_valid = color_valid_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_ack     = cpu_ack_q;

endmodule

// File: tb/tb_color_palette_ctrl.sv
// Directed bench for color_palette_ctrl: CPU access, pixel pipeline, starvation, reset and layer sweep.
module tb_color_palette_ctrl;

`ifdef COLOR_PALETTE_SNOW_EN
  localparam bit SNOW = 1'b1;
`else
  localparam bit SNOW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [31:0] layer_idx;
  logic [1:0]  layer_sel;
  logic [1:0]  bank_sel;
  logic [15:0] color_out;
  logic        color_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [9:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;

  int tests = 0;
  int fails = 0;

  // Expected colour pipeline: slot 0 is due in the next window, slot 1 one window later.
  logic        pipe_v [2];
  logic [15:0] pipe_c [2];
  logic [15:0] last_col;
  bit          steal_armed;
  logic [15:0] steal_data;

  always #5 clk = ~clk;

  color_palette_ctrl dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .layer_idx(layer_idx),
    .layer_sel(layer_sel), .bank_sel(bank_sel), .color_out(color_out),
    .color_valid(color_valid), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack)
  );

  // Palette contents preloaded for bank 1; lanes hold indices 0x01, 0x02, 0x05, 0x03.
  function automatic logic [15:0] col_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return 16'h1111;
      2'd1:    return 16'h2222;
      2'd2:    return 16'h7C1F;
      default: return 16'h3333;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (steal_armed && cpu_ack && pipe_v[0]) pipe_c[0] = SNOW ? steal_data : last_col;
    tests++;
    if (color_valid !== pipe_v[0]) begin
      fails++;
      $display("FAIL color_valid at %0t: got %b expected %b", $time, color_valid, pipe_v[0]);
    end else if (pipe_v[0]) begin
      tests++;
      if (color_out !== pipe_c[0]) begin
        fails++;
        $display("FAIL color_out at %0t: got %h expected %h", $time, color_out, pipe_c[0]);
      end
    end
    if (pipe_v[0]) last_col = pipe_c[0];
    pipe_v[0] = pipe_v[1];
    pipe_c[0] = pipe_c[1];
    pipe_v[1] = 1'b0;
  endtask

  task automatic drive_pix(input bit pv, input logic [1:0] sel);
    pix_valid = pv;
    layer_sel = sel;
    pipe_v[1] = pv;
    pipe_c[1] = col_of(sel);
  endtask

  task automatic cpu_op(input bit we, input logic [9:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input int exp_lat, input string name);
    int lat;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!cpu_ack && lat < 20);
    cpu_req = 1'b0;
    tests++;
    if (!cpu_ack || lat != exp_lat) begin
      fails++;
      $display("FAIL %s ack latency: got %0d (ack=%b) expected %0d", name, lat, cpu_ack, exp_lat);
    end
    tests++;
    if (cpu_rdata !== exp_rd) begin
      fails++;
      $display("FAIL %s rdata: got %h expected %h", name, cpu_rdata, exp_rd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pipe_v[0] = 1'b0; pipe_v[1] = 1'b0;
    tick(); tick();
    tests++;
    if (color_out !== 16'h0 || cpu_ack !== 1'b0 || cpu_rdata !== 16'h0) begin
      fails++;
      $display("FAIL reset outputs: got color=%h ack=%b rdata=%h expected 0 0 0", color_out, cpu_ack, cpu_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_cpu_access();
    cpu_op(1'b1, 10'h105, 16'h7C1F, 16'h7C1F, 2, "cpu_write_105");
    tick();
    cpu_op(1'b0, 10'h105, 16'h0000, 16'h7C1F, 2, "cpu_read_105");
    tick();
    cpu_op(1'b1, 10'h101, 16'h1111, 16'h1111, 2, "preload_101");
    tick();
    cpu_op(1'b1, 10'h102, 16'h2222, 16'h2222, 2, "preload_102");
    tick();
    cpu_op(1'b1, 10'h103, 16'h3333, 16'h3333, 2, "preload_103");
    tick();
  endtask

  task automatic test_pixel_latency();
    drive_pix(1'b1, 2'd2);
    tick();
    drive_pix(1'b0, 2'd0);
    tick(); tick(); tick();
  endtask

  task automatic test_back_to_back_sweep();
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 4; s++) begin
        drive_pix(1'b1, 2'(s));
        tick();
      end
    end
    drive_pix(1'b0, 2'd0);
    tick(); tick();
  endtask

  task automatic test_starvation();
    int  lat;
    int  acks;
    bit  waiting;
    acks = 0; lat = 0; waiting = 1'b0;
    steal_armed = 1'b1;
    steal_data  = 16'hBEEF;
    for (int k = 0; k < 24; k++) begin
      drive_pix(1'b1, (k % 2 == 1) ? 2'd1 : 2'd0);
      if (k == 4) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h1A0; cpu_wdata = 16'hBEEF;
        waiting = 1'b1;
      end
      tick();
      if (cpu_ack) acks++;
      if (waiting) begin
        lat++;
        if (cpu_ack) begin
          waiting = 1'b0;
          cpu_req = 1'b0;
          tests++;
          if (lat > 10) begin
            fails++;
            $display("FAIL starve ack latency: got %0d expected at most 10", lat);
          end
        end else if (lat >= 14) begin
          waiting = 1'b0;
          cpu_req = 1'b0;
          tests++; fails++;
          $display("FAIL starve ack timeout: got no ack after %0d cycles expected at most 10", lat);
        end
      end
    end
    drive_pix(1'b0, 2'd0);
    tick(); tick();
    steal_armed = 1'b0;
    tests++;
    if (acks != 1) begin
      fails++;
      $display("FAIL starve ack count: got %0d expected 1", acks);
    end
    cpu_op(1'b0, 10'h1A0, 16'h0000, 16'hBEEF, 2, "starve_readback");
    tick();
  endtask

  task automatic test_toggle_grant();
    int  lat;
    bit  waiting;
    lat = 0; waiting = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive_pix(k % 2 == 0, 2'(k % 4));
      if (k == 2) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h105; cpu_wdata = 16'h0;
        waiting = 1'b1;
      end
      tick();
      if (waiting) begin
        lat++;
        if (cpu_ack || lat >= 8) begin
          waiting = 1'b0;
          cpu_req = 1'b0;
          tests++;
          if (!cpu_ack || lat != 3) begin
            fails++;
            $display("FAIL toggle ack latency: got %0d (ack=%b) expected 3", lat, cpu_ack);
          end
          tests++;
          if (cpu_rdata !== 16'h7C1F) begin
            fails++;
            $display("FAIL toggle rdata: got %h expected 7c1f", cpu_rdata);
          end
        end
      end
    end
    drive_pix(1'b0, 2'd0);
    tick(); tick();
  endtask

  task automatic test_reset_in_wait();
    drive_pix(1'b1, 2'd2);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h105; cpu_wdata = 16'h0BAD;
    tick();
    drive_pix(1'b1, 2'd2);
    rst = 1'b1;
    cpu_req = 1'b0;
    pipe_v[0] = 1'b0; pipe_v[1] = 1'b0;
    tick();
    tests++;
    if (cpu_ack !== 1'b0 || color_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_wait outputs: got ack=%b valid=%b expected 0 0", cpu_ack, color_valid);
    end
    rst = 1'b0;
    drive_pix(1'b0, 2'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (cpu_ack !== 1'b0) begin
        fails++;
        $display("FAIL reset_wait stray ack: got %b expected 0", cpu_ack);
      end
    end
    cpu_op(1'b0, 10'h105, 16'h0000, 16'h7C1F, 2, "reset_wait_readback");
    tick();
  endtask

  initial begin
    rst = 1'b1; pix_valid = 1'b0; layer_sel = 2'd0; bank_sel = 2'd1;
    layer_idx = {8'h03, 8'h05, 8'h02, 8'h01};
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    pipe_v[0] = 1'b0; pipe_v[1] = 1'b0; pipe_c[0] = '0; pipe_c[1] = '0;
    last_col = '0; steal_armed = 1'b0; steal_data = '0;
    test_reset();
    test_cpu_access();
    test_pixel_latency();
    test_back_to_back_sweep();
    test_starvation();
    test_toggle_grant();
    test_reset_in_wait();
    test_back_to_back_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
